// File: rtl/cia_pkg.sv
// Shared CIA definitions: register types, the ICR address, the interrupt
// servicer state encoding and the queued-event record.
package cia;

  typedef logic [3:0] reg4_t;
  typedef logic [7:0] reg8_t;

  // Interrupt control register: reading it returns and clears the sources.
  localparam reg4_t ICR_ADDR = 4'hD;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    READ,
    HOLD
  } irq_state_t;

  // One serviced interrupt: IR bit, source flags, PHI2 timestamp.
  typedef struct packed {
    logic        ir;
    logic [4:0]  flags;
    logic [15:0] stamp;
  } irq_event_t;

  localparam int unsigned EVENT_W    = $bits(irq_event_t);
  localparam int unsigned FIFO_DEPTH = 4;

endpackage

// File: rtl/cia_irq_fifo.sv
// Small synchronous FIFO for serviced-interrupt events.
// Ports:
//   clk, res_n  - clock, asynchronous active-low reset
//   push        - write push_data this cycle (ignored when full unless a pop
//                 happens on the same edge, which frees the slot first)
//   push_data   - entry to write
//   pop         - drop the head entry (ignored when empty)
//   head        - current head entry (meaningless while empty)
//   empty, full - occupancy flags
module cia_irq_fifo #(
  parameter int unsigned WIDTH = 22,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees a slot, so a full FIFO still accepts it.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  // NOTE: the storage array is deliberately not reset; validity is tracked by
  // count, and leaving it unreset lets it map onto plain RAM/flops without
  // reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cia_irq_servicer.sv
// CIA interrupt servicer: when /IRQ is seen low at a PHI2 rising edge, it
// reads the ICR one PHI2 cycle later, timestamps the result with a free
// running PHI2 cycle counter and queues it in a 4-entry event FIFO.
// Ports:
//   clk, res_n         - clock, asynchronous active-low reset
//   phi2_up, phi2_dn   - one-clk strobes on PHI2 rising / falling edges
//   en                 - allows new services to start (IDLE->ARM only)
//   irq_n              - CIA /IRQ line
//   rd, addr, rd_data  - bus read request, register address, read-back data
//   ev_valid, ev_ready - event stream handshake (pop on valid & ready)
//   ev_flags, ev_ir    - head event ICR bits 4:0 and bit 7
//   ev_stamp           - head event PHI2 cycle timestamp
//   lost               - saturating count of events dropped on a full FIFO
module cia_irq_servicer
  import cia::*;
(
  input  logic        clk,
  input  logic        res_n,
  input  logic        phi2_up,
  input  logic        phi2_dn,
  input  logic        en,
  input  logic        irq_n,
  output logic        rd,
  output reg4_t       addr,
  input  reg8_t       rd_data,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [4:0]  ev_flags,
  output logic        ev_ir,
  output logic [15:0] ev_stamp,
  output logic [7:0]  lost
);

  irq_state_t  state_q;
  irq_state_t  state_d;
  logic [15:0] cycle_cnt;
  logic [15:0] stamp_q;
  logic        hold_q;
  logic        capture;
  logic        pop;
  logic        fifo_empty;
  logic        fifo_full;
  irq_event_t  cap_ev;
  irq_event_t  head_ev;
  logic        unused_rd_bits;

  // ICR bits 6:5 are not part of the event record.
  assign unused_rd_bits = ^rd_data[6:5];

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n)       cycle_cnt <= '0;
    else if (phi2_up) cycle_cnt <= cycle_cnt + 16'd1;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // hold_q marks the first PHI2 rising edge seen in HOLD; the second exits.
  // The stamp is the counter value the READ state starts with, i.e. the
  // post-increment value of the phi2_up that enters READ.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      hold_q  <= 1'b0;
      stamp_q <= '0;
    end else begin
      if (state_q != HOLD) hold_q <= 1'b0;
      else if (phi2_up)    hold_q <= 1'b1;
      if (state_q == ARM && phi2_up) stamp_q <= cycle_cnt + 16'd1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    rd      = 1'b0;
    addr    = '0;
    case (state_q)
      IDLE: if (phi2_up && en && !irq_n) state_d = ARM;
      ARM:  if (phi2_up) state_d = READ;
      READ: begin
        // rd decodes straight from the state so reset drops it at once.
        rd   = 1'b1;
        addr = ICR_ADDR;
        if (phi2_dn) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD:    if (phi2_up && hold_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cap_ev = '{ir: rd_data[7], flags: rd_data[4:0], stamp: stamp_q};

  cia_irq_fifo #(
    .WIDTH(EVENT_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .res_n    (res_n),
    .push     (capture),
    .push_data(cap_ev),
    .pop      (pop),
    .head     (head_ev),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign ev_valid = !fifo_empty;
  assign pop      = ev_valid && ev_ready;
  assign ev_flags = head_ev.flags;
  assign ev_ir    = head_ev.ir;
  assign ev_stamp = head_ev.stamp;

  // A same-edge pop makes room, so only an unrelieved full FIFO drops.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) lost <= '0;
    else if (capture && fifo_full && !pop && lost != 8'hFF) lost <= lost + 8'd1;
  end

endmodule

// File: tb/tb_cia_irq_servicer.sv
// Self-checking bench for cia_irq_servicer. A timeline reference model
// (PHI2 edge counting plus an event queue) predicts every output after
// each clock edge; directed scenarios add explicit spot checks.
module tb_cia_irq_servicer;

  logic        clk = 1'b0;
  logic        res_n;
  logic        phi2_up;
  logic        phi2_dn;
  logic        en;
  logic        irq_n;
  logic        rd;
  logic [3:0]  addr;
  logic [7:0]  rd_data;
  logic        ev_valid;
  logic        ev_ready;
  logic [4:0]  ev_flags;
  logic        ev_ir;
  logic [15:0] ev_stamp;
  logic [7:0]  lost;

  cia_irq_servicer dut (
    .clk     (clk),
    .res_n   (res_n),
    .phi2_up (phi2_up),
    .phi2_dn (phi2_dn),
    .en      (en),
    .irq_n   (irq_n),
    .rd      (rd),
    .addr    (addr),
    .rd_data (rd_data),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_flags(ev_flags),
    .ev_ir   (ev_ir),
    .ev_stamp(ev_stamp),
    .lost    (lost)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic       ir;
    logic [4:0] flags;
    logic [15:0] stamp;
  } ev_m_t;

  ev_m_t       mq[$];
  logic [15:0] m_cnt;      // PHI2 rising edges since reset, mod 2^16
  int          m_busy;     // PHI2 rising edges left before the next IRQ check
  bit          m_reading;  // ICR read in progress
  logic [15:0] m_stamp;
  int          m_lost;

  int  n_checks = 0;
  int  n_pass   = 0;
  int  rd_hi;
  int  dut_pops;
  bit  ready_at_capture = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_cnt     = '0;
    m_busy    = 0;
    m_reading = 1'b0;
    m_stamp   = '0;
    m_lost    = 0;
  endtask

  // One clock with the given strobes; the model advances by the same edge,
  // then all outputs are compared 1 time unit after it.
  task automatic step(input bit up, input bit dn);
    bit    do_pop;
    ev_m_t e;
    phi2_up = up;
    phi2_dn = dn;
    if (ev_valid === 1'b1 && ev_ready === 1'b1) dut_pops++;
    @(posedge clk);
    do_pop = ev_ready && (mq.size() > 0);
    if (do_pop) e = mq.pop_front();
    if (dn && m_reading) begin
      e.ir    = rd_data[7];
      e.flags = rd_data[4:0];
      e.stamp = m_stamp;
      if (mq.size() < 4) mq.push_back(e);
      else if (m_lost < 255) m_lost++;
      m_reading = 1'b0;
    end
    if (up) begin
      m_cnt = m_cnt + 16'd1;
      if (m_busy == 0) begin
        // A service spans the check edge plus three more rising edges.
        if (en && !irq_n) m_busy = 3;
      end else begin
        m_busy--;
        if (m_busy == 2) begin
          m_reading = 1'b1;
          m_stamp   = m_cnt;
        end
      end
    end
    #1;
    phi2_up = 1'b0;
    phi2_dn = 1'b0;
    check("rd", rd, m_reading);
    check("addr", addr, m_reading ? 32'hD : 32'h0);
    check("ev_valid", ev_valid, mq.size() > 0);
    check("lost", lost, m_lost);
    if (mq.size() > 0) begin
      check("ev_flags", ev_flags, mq[0].flags);
      check("ev_ir", ev_ir, mq[0].ir);
      check("ev_stamp", ev_stamp, mq[0].stamp);
    end
    if (rd === 1'b1) rd_hi++;
  endtask

  task automatic phi2_cycle(input int gap);
    step(1'b1, 1'b0);
    repeat (gap) step(1'b0, 1'b0);
    if (ready_at_capture) ev_ready = m_reading;
    step(1'b0, 1'b1);
    if (ready_at_capture) ev_ready = 1'b0;
    repeat (gap) step(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    res_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd", rd, 1'b0);
    check("rst_addr", addr, 4'h0);
    check("rst_ev_valid", ev_valid, 1'b0);
    check("rst_lost", lost, 8'h00);
    res_n = 1'b1;
  endtask

  initial begin
    logic [7:0] lost_saved;
    res_n    = 1'b0;
    phi2_up  = 1'b0;
    phi2_dn  = 1'b0;
    en       = 1'b1;
    irq_n    = 1'b1;
    rd_data  = 8'h00;
    ev_ready = 1'b0;
    rd_hi    = 0;
    dut_pops = 0;
    do_reset();

    // Idle: 100 PHI2 cycles with /IRQ high.
    rd_hi = 0;
    for (int i = 0; i < 100; i++) phi2_cycle(1);
    check("idle_rd_count", rd_hi, 0);
    check("idle_ev_valid", ev_valid, 1'b0);
    check("idle_lost", lost, 8'h00);

    // Single IRQ checked at cycle 10, ICR = 0x81.
    do_reset();
    for (int i = 0; i < 10; i++) phi2_cycle(1);
    irq_n   = 1'b0;
    rd_data = 8'h81;
    rd_hi   = 0;
    phi2_cycle(1);
    irq_n = 1'b1;
    repeat (4) phi2_cycle(1);
    check("single_rd_len", rd_hi, 2);
    check("single_valid", ev_valid, 1'b1);
    check("single_flags", ev_flags, 5'h01);
    check("single_ir", ev_ir, 1'b1);
    check("single_stamp", ev_stamp, 16'd12);
    ev_ready = 1'b1;
    step(1'b0, 1'b0);
    ev_ready = 1'b0;
    check("single_popped", ev_valid, 1'b0);

    // Overflow: six services with the sink stalled.
    irq_n = 1'b0;
    for (int i = 0; i < 24; i++) begin
      rd_data = 8'(i + 1);
      phi2_cycle(1);
    end
    irq_n = 1'b1;
    repeat (3) phi2_cycle(1);
    check("ovf_lost", lost, 8'd2);
    dut_pops = 0;
    ev_ready = 1'b1;
    repeat (6) step(1'b0, 1'b0);
    ev_ready = 1'b0;
    check("ovf_drain_count", dut_pops, 4);

    // Full FIFO with a pop on the capture clock.
    irq_n = 1'b0;
    for (int i = 0; i < 16; i++) phi2_cycle(1);
    lost_saved       = lost;
    ready_at_capture = 1'b1;
    rd_data          = 8'h9F;
    phi2_cycle(1);
    irq_n = 1'b1;
    repeat (3) phi2_cycle(1);
    ready_at_capture = 1'b0;
    check("fullpop_lost", lost, 8'd2);
    check("fullpop_lost_same", lost, lost_saved);
    dut_pops = 0;
    ev_ready = 1'b1;
    repeat (6) step(1'b0, 1'b0);
    ev_ready = 1'b0;
    check("fullpop_drain_count", dut_pops, 4);

    // Reset asserted while the ICR read is in flight.
    irq_n   = 1'b0;
    rd_data = 8'h82;
    repeat (4) phi2_cycle(1);
    phi2_cycle(1);
    step(1'b1, 1'b0);
    check("pre_rst_rd", rd, 1'b1);
    check("pre_rst_valid", ev_valid, 1'b1);
    res_n = 1'b0;
    #1;
    check("rst_read_rd", rd, 1'b0);
    check("rst_read_addr", addr, 4'h0);
    check("rst_read_valid", ev_valid, 1'b0);
    model_reset();
    irq_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    res_n = 1'b1;
    irq_n = 1'b0;
    phi2_cycle(1);
    irq_n = 1'b1;
    repeat (4) phi2_cycle(1);
    check("post_rst_valid", ev_valid, 1'b1);
    check("post_rst_stamp", ev_stamp, 16'd2);
    check("post_rst_flags", ev_flags, 5'h02);

    // Spurious interrupt whose READ entry wraps the counter to 0x0000.
    do_reset();
    for (int i = 0; i < 70000 && m_cnt != 16'hFFFE; i++) step(1'b1, 1'b0);
    check("wrap_reached", m_cnt == 16'hFFFE, 1'b1);
    irq_n   = 1'b0;
    rd_data = 8'h04;
    phi2_cycle(1);
    irq_n = 1'b1;
    repeat (4) phi2_cycle(1);
    check("spur_valid", ev_valid, 1'b1);
    check("spur_ir", ev_ir, 1'b0);
    check("spur_flags", ev_flags, 5'h04);
    check("wrap_stamp", ev_stamp, 16'h0000);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      irq_n    = $urandom_range(0, 1) != 0;
      ev_ready = ($urandom_range(0, 3) == 0);
      rd_data  = 8'($urandom);
      phi2_cycle(int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cia_irq_servicer.md
CIA_IRQ_SERVICER -- requirements
Module: cia_irq_servicer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk (1-bit, all state updates on rising edge) and res_n (1-bit, asynchronous active-low reset).
REQ-002 SHALL have ports, clock and reset first: clk in 1; res_n in 1; phi2_up in 1 (one-clk strobe, PHI2 rising); phi2_dn in 1 (one-clk strobe, PHI2 falling); en in 1 (service enable); irq_n in 1 (CIA /IRQ).
REQ-003 SHALL have further ports: rd out 1 (bus read request); addr out cia::reg4_t (register address); rd_data in cia::reg8_t (ICR read-back).
REQ-004 SHALL have event-stream ports: ev_valid out 1; ev_ready in 1; ev_flags out 5 (ICR bits 4:0); ev_ir out 1 (ICR bit 7); ev_stamp out 16 (PHI2 cycle timestamp); lost out 8 (dropped-event count).

Function
REQ-005 SHALL keep a 16-bit cycle counter that increments on every phi2_up and wraps from 0xFFFF to 0x0000.
REQ-006 SHALL run a state machine with states IDLE, ARM, READ, HOLD.
REQ-007 IDLE: on phi2_up with en=1 and irq_n=0 -> ARM; otherwise remain in IDLE.
REQ-008 ARM: on the next phi2_up -> READ; drive rd=1 and addr=ICR_ADDR (0xD) from entry into READ until exit.
REQ-009 READ: on phi2_dn, capture rd_data[7] and rd_data[4:0], plus the cycle-counter value at READ entry, as one event -> HOLD; rd=0 and addr=0x0 in all other states.
REQ-010 HOLD: wait for two phi2_up strobes, then -> IDLE; a still-low irq_n then re-triggers the IDLE rule.
REQ-011 SHALL buffer events in a 4-entry FIFO; ev_valid=1 while the FIFO is non-empty; ev_flags, ev_ir and ev_stamp show the head entry.
REQ-012 SHALL pop the FIFO on a clk edge with ev_valid=1 and ev_ready=1; ev_* are don't-care while ev_valid=0.
REQ-013 Capture with the FIFO full: the event SHALL be dropped, and lost SHALL increment, saturating at 0xFF.
REQ-014 Capture and pop on the same clk with the FIFO full: the pop SHALL take effect first, and the new event SHALL be stored (not lost).
REQ-015 en=0 SHALL affect only the IDLE->ARM transition; an in-progress ARM/READ/HOLD sequence completes.
REQ-016 A capture with rd_data[7]=0 SHALL still be queued, with ev_ir=0, to mark a spurious interrupt.
REQ-017 phi2_up and phi2_dn are mutually exclusive; if both are asserted, behaviour is unspecified.

Reset
REQ-018 While res_n=0, SHALL hold state=IDLE, rd=0, addr=0x0, FIFO empty (ev_valid=0), lost=0x00, and cycle counter=0x0000.
REQ-019 Reset asserted during READ SHALL abort the read immediately (rd=0 asynchronously), and no event SHALL be queued.
REQ-020 After res_n rises, the first IRQ check SHALL occur at the first subsequent phi2_up.

Structure
REQ-021 ICR_ADDR (4'hD) and the state enum SHALL live in the shared cia package, which already defines reg4_t and reg8_t.
REQ-022 The FIFO SHALL be a sub-module, cia_irq_fifo, parameterised on width (22) and depth (4).

Verification
REQ-023 Idle: irq_n held 1 for 100 PHI2 cycles -> rd never asserted, ev_valid=0, lost=0.
REQ-024 Single IRQ: irq_n=0 at cycle 10, rd_data=0x81 -> rd=1 with addr=0xD for one PHI2 cycle; event ev_flags=0x01, ev_ir=1, ev_stamp=12.
REQ-025 Overflow: ev_ready=0 with 6 IRQs serviced -> 4 events queued, lost=2; drain returns stamps in capture order.
REQ-026 Full plus same-clk pop at capture -> FIFO stays at 4 entries, lost unchanged.
REQ-027 Reset during READ: res_n=0 -> rd=0 in the same clk, ev_valid=0; after release, irq_n=0 is serviced normally.
REQ-028 Spurious: rd_data=0x04 -> event with ev_ir=0 and ev_flags=0x04; counter wrap from 0xFFFF gives ev_stamp=0x0000.
